// File: rtl/ramp_gen_if.sv
// Control and output bundle of the ramp generator.
// master: the block that programs the ramps and consumes value/tick/wrap.
// slave:  the ramp generator itself.
// There is no valid/ready pairing: control inputs are sampled every clock,
// load and the tick/wrap outputs are single-cycle pulses.
interface ramp_gen_if #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 16
);
    logic                      enable;
    logic [1:0]                mode;
    logic [PRESCALE_W-1:0]     prescale;
    logic                      load;
    logic [CHANNELS*WIDTH-1:0] phase;
    logic [CHANNELS*WIDTH-1:0] value;
    logic                      tick;
    logic [CHANNELS-1:0]       wrap;

    modport master (
        output enable, mode, prescale, load, phase,
        input  value, tick, wrap
    );

    modport slave (
        input  enable, mode, prescale, load, phase,
        output value, tick, wrap
    );
endinterface

// File: rtl/ramp_gen.sv
// Multi-channel brightness ramp generator. A shared prescaler produces step
// events; each channel keeps a WIDTH+1 bit phase accumulator whose value is
// mapped to sawtooth up/down, triangle, or a static level. value, tick and
// wrap all appear two clocks after the step that caused them.
module ramp_gen #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 16
) (
    input logic         clk,
    input logic         rst,
    ramp_gen_if.slave   bus
);

    localparam logic [1:0] MODE_UP     = 2'd0;
    localparam logic [1:0] MODE_DOWN   = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_STATIC = 2'd3;

    localparam logic [WIDTH:0]      ACC_ONE = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] CNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0]     cnt;
    logic [WIDTH:0]            acc [CHANNELS];
    logic                      step;
    logic [CHANNELS-1:0]       wrap_now;
    logic                      tick_d;
    logic [CHANNELS-1:0]       wrap_d;
    logic                      tick_q;
    logic [CHANNELS-1:0]       wrap_q;
    logic [CHANNELS*WIDTH-1:0] value_q;

    assign bus.value = value_q;
    assign bus.tick  = tick_q;
    assign bus.wrap  = wrap_q;

    // Step decision and per-channel period-boundary detection for this clock.
    // The >= compare lets a lowered prescale fire immediately instead of
    // counting all the way round.
    always_comb begin
        step = bus.enable && !bus.load && (bus.mode != MODE_STATIC) &&
               (cnt >= bus.prescale);
        wrap_now = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (step) begin
                if (bus.mode == MODE_TRI) begin
                    wrap_now[i] = &acc[i];
                end else begin
                    wrap_now[i] = &acc[i][WIDTH-1:0];
                end
            end
        end
    end

    // Prescaler and phase accumulators; load wins over stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
        end else if (bus.load) begin
            cnt <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= {1'b0, bus.phase[i*WIDTH +: WIDTH]};
            end
        end else if (step) begin
            cnt <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= acc[i] + ACC_ONE;
            end
        end else if (bus.enable && (bus.mode != MODE_STATIC)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Two-stage delay of step/wrap so the pulses line up with the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_d <= 1'b0;
            wrap_d <= '0;
            tick_q <= 1'b0;
            wrap_q <= '0;
        end else begin
            tick_d <= step;
            wrap_d <= wrap_now;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    // Output mapping from the current accumulator and mode, registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                case (bus.mode)
                    MODE_UP:   value_q[i*WIDTH +: WIDTH] <= acc[i][WIDTH-1:0];
                    MODE_DOWN: value_q[i*WIDTH +: WIDTH] <= ~acc[i][WIDTH-1:0];
                    MODE_TRI:  value_q[i*WIDTH +: WIDTH] <= acc[i][WIDTH] ?
                                                            ~acc[i][WIDTH-1:0] :
                                                            acc[i][WIDTH-1:0];
                    default:   value_q[i*WIDTH +: WIDTH] <= bus.phase[i*WIDTH +: WIDTH];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ramp_gen.sv
// Bench for ramp_gen: directed scenarios followed by a randomized run, all
// compared every clock against an arithmetic model of the ramp rules.
module tb_ramp_gen;
    localparam int CHANNELS   = 4;
    localparam int WIDTH      = 8;
    localparam int PRESCALE_W = 16;
    localparam int LOOP       = 1 << WIDTH;
    localparam int MAXV       = LOOP - 1;
    localparam int PER        = 1 << (WIDTH + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ramp_gen_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bus ();

    ramp_gen #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;

    int                        m_acc [CHANNELS];
    int                        m_cnt;
    logic                      prev_s;
    logic [CHANNELS-1:0]       prev_w;
    logic [CHANNELS*WIDTH-1:0] exp_value;
    logic                      exp_tick;
    logic [CHANNELS-1:0]       exp_wrap;

    // Ramp shape as plain arithmetic on the accumulator's position.
    function automatic int map_val(int acc, int mode, int ph);
        case (mode)
            0:       return acc % LOOP;
            1:       return MAXV - (acc % LOOP);
            2:       return (acc < LOOP) ? acc : (PER - 1 - acc);
            default: return ph;
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        logic                      s;
        logic [CHANNELS-1:0]       w;
        logic [CHANNELS*WIDTH-1:0] mapped;
        int                        ph;
        s = 1'b0;
        w = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ph = int'(bus.phase[i*WIDTH +: WIDTH]);
            mapped[i*WIDTH +: WIDTH] = WIDTH'(map_val(m_acc[i], int'(bus.mode), ph));
        end
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) m_acc[i] = 0;
            m_cnt     = 0;
            exp_value = '0;
            exp_tick  = 1'b0;
            exp_wrap  = '0;
        end else begin
            exp_value = mapped;
            exp_tick  = prev_s;
            exp_wrap  = prev_w;
            if (bus.load) begin
                for (int i = 0; i < CHANNELS; i++)
                    m_acc[i] = int'(bus.phase[i*WIDTH +: WIDTH]);
                m_cnt = 0;
            end else if (bus.enable && bus.mode != 2'd3) begin
                if (m_cnt >= int'(bus.prescale)) begin
                    s = 1'b1;
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (bus.mode == 2'd2) w[i] = (m_acc[i] == PER - 1);
                        else                  w[i] = ((m_acc[i] % LOOP) == MAXV);
                        m_acc[i] = (m_acc[i] + 1) % PER;
                    end
                    m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
        prev_s = s;
        prev_w = w;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step_clk();
        @(posedge clk);
        model_edge();
        #1;
        check("value", 64'(bus.value), 64'(exp_value));
        check("tick",  64'(bus.tick),  64'(exp_tick));
        check("wrap",  64'(bus.wrap),  64'(exp_wrap));
    endtask

    task automatic run(int n);
        repeat (n) step_clk();
    endtask

    task automatic drive(logic en, logic [1:0] md, int pre, logic ld,
                         logic [CHANNELS*WIDTH-1:0] ph);
        bus.enable   = en;
        bus.mode     = md;
        bus.prescale = PRESCALE_W'(pre);
        bus.load     = ld;
        bus.phase    = ph;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        for (int i = 0; i < CHANNELS; i++) m_acc[i] = 0;
        m_cnt  = 0;
        prev_s = 1'b0;
        prev_w = '0;

        // Reset with random inputs
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 5),
                  1'($urandom_range(0, 1)), $urandom);
            step_clk();
        end
        check("reset_value", 64'(bus.value), 64'd0);
        check("reset_tick",  64'(bus.tick),  64'd0);
        check("reset_wrap",  64'(bus.wrap),  64'd0);
        rst = 1'b0;

        // Sawtooth up, step every clock
        drive(1'b1, 2'd0, 0, 1'b0, '0);
        run(600);

        // Triangle from zero
        drive(1'b1, 2'd2, 0, 1'b1, '0);
        step_clk();
        bus.load = 1'b0;
        run(1100);

        // Phase load in down mode
        drive(1'b0, 2'd1, 0, 1'b0, 32'hC0804000);
        run(3);
        bus.load = 1'b1;
        step_clk();
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        step_clk();
        check("load_down_value", 64'(bus.value), 64'h3F7FBFFF);
        check("load_tick",       64'(bus.tick),  64'd0);
        check("load_wrap",       64'(bus.wrap),  64'd0);
        run(20);

        // Prescale 3, then freeze
        bus.prescale = 16'd3;
        run(40);
        bus.enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.phase = $urandom;
            step_clk();
        end
        bus.enable = 1'b1;
        run(8);

        // Lower prescale mid-count: step on the next enabled clock
        drive(1'b1, 2'd0, 100, 1'b1, '0);
        step_clk();
        bus.load = 1'b0;
        run(50);
        bus.prescale = 16'd2;
        step_clk();
        step_clk();
        check("prescale_drop_tick", 64'(bus.tick), 64'd1);
        run(10);

        // Reset while triangle descends through 200
        drive(1'b1, 2'd2, 0, 1'b1, 32'h000000C8);
        step_clk();
        bus.load = 1'b0;
        n = 0;
        while (!(exp_value[WIDTH-1:0] == 8'd200 && m_acc[0] >= LOOP) && n < 400) begin
            step_clk();
            n++;
        end
        check("reach_desc_200", 64'(n < 400), 64'd1);
        rst = 1'b1;
        step_clk();
        check("midrun_reset_value", 64'(bus.value), 64'd0);
        rst = 1'b0;
        run(12);

        // Static level
        drive(1'b1, 2'd3, 0, 1'b0, 32'h5A5A5A5A);
        step_clk();
        check("static_value", 64'(bus.value), 64'h5A5A5A5A);
        run(10);

        // Randomized run
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 49) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) bus.prescale = PRESCALE_W'($urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) bus.phase = $urandom;
            bus.enable = ($urandom_range(0, 9) != 0);
            bus.load   = ($urandom_range(0, 59) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            step_clk();
        end
        rst = 1'b0;

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ramp_gen.md
Name: ramp_gen

Overview:
- Multi-channel, parametrised brightness ramp generator that feeds the PWM comparators.
- Each channel runs an independent phase accumulator stepped by a shared programmable prescaler.
- Each channel produces a sawtooth-up, sawtooth-down, triangle or static level of WIDTH bits.
- Per-channel phase offsets are loadable, so channels can be staggered, for example for chase or breathing effects.

Parameters:
- CHANNELS, 4, number of independent output channels.
- WIDTH, 8, bits per channel output value.
- PRESCALE_W, 16, width of the prescaler compare value.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  high: prescaler and accumulators advance; low: freeze.
- mode  in  2  0 sawtooth up, 1 sawtooth down, 2 triangle, 3 static.
- prescale  in  PRESCALE_W  a step occurs every prescale+1 enabled clocks.
- load  in  1  one-cycle pulse: load phase offsets into all accumulators.
- phase  in  CHANNELS*WIDTH  per-channel offset / static level; channel i occupies bits [i*WIDTH +: WIDTH].
- value  out  CHANNELS*WIDTH  per-channel ramp output, same packing as phase; registered.
- tick  out  1  one-cycle pulse, aligned with each value step.
- wrap  out  CHANNELS  per-channel one-cycle pulse, aligned with value, on ramp period completion.

Behaviour:
- Reset:
  - Prescaler count cnt = 0.
  - Every accumulator acc_i (WIDTH+1 bits) = 0.
  - value = 0, tick = 0, wrap = 0, independent of mode.
  - Reset overrides load and enable in the same cycle.
- Prescaler:
  - cnt is PRESCALE_W bits.
  - Step event S asserts in a cycle when enable=1, load=0, mode!=3 and cnt >= prescale.
  - On S: cnt <= 0. Otherwise, if enable=1: cnt <= cnt+1.
  - The >= compare means lowering prescale mid-count causes a step on the next enabled clock, with no 2^PRESCALE_W overrun.
  - prescale=0 steps on every enabled clock.
- Accumulators:
  - On S: acc_i <= acc_i + 1, modulo 2^(WIDTH+1).
  - In mode 3, or when enable=0, acc_i and cnt hold.
- Load:
  - When load=1 (and rst=0): acc_i <= {1'b0, phase_i} and cnt <= 0.
  - Load has priority over S and acts regardless of enable.
  - A load produces no tick and no wrap.
- Output mapping (registered every clock from the current acc_i and mode; value lags acc by 1 clock):
  - Mode 0: value_i = acc_i[WIDTH-1:0].
  - Mode 1: value_i = ~acc_i[WIDTH-1:0].
  - Mode 2: value_i = acc_i[WIDTH] ? ~acc_i[WIDTH-1:0] : acc_i[WIDTH-1:0]. This gives 0..max, max..0 with period 2^(WIDTH+1) steps; each peak and trough value is held for 2 steps.
  - Mode 3: value_i = phase_i, tracking phase live with 1-clock latency.
- Latency:
  - S in cycle n: acc updates at the end of cycle n; the new value is visible in cycle n+2.
  - tick is high exactly in cycle n+2: S is delayed through two registers.
- Wrap:
  - wrap_i is flagged on S if the acc_i increment crosses a period boundary:
    - Modes 0/1: acc_i[WIDTH-1:0] goes from all-ones to 0.
    - Mode 2: acc_i goes from all-ones (WIDTH+1 bits) to 0.
  - wrap_i is delayed identically to tick, so it is coincident with the value that starts the new period.
- Mode change mid-run:
  - acc is not reset.
  - The new mapping applies from the next value update.
- Enable low:
  - value, acc and cnt hold.
  - tick and wrap events already in the pipe still emerge, at most 2 cycles later.
- Channel independence: all channels share S; they differ only by phase offset.

Test Plan:
- Reset check: rst high for 3 clocks with random inputs -> value=0, tick=0, wrap=0 in the cycle after reset; cnt and acc clear.
- Sawtooth up: mode=0, prescale=0, enable=1, WIDTH=8 -> ch0 value 0,1,...,255,0 on consecutive clocks; tick every clock; wrap[0] high only when value returns to 0, every 256 ticks.
- Triangle: mode=2, prescale=0 -> sequence 0..255, 255..0, period 512 ticks; wrap only at the 0 following the descending 0; peak 255 and trough 0 each appear twice.
- Phase load and down mode:
  - Set phase = {8'hC0, 8'h80, 8'h40, 8'h00} and pulse load, mode=1 -> ch0..ch3 show 255, 191, 127, 63 in the same cycle; no tick or wrap for the load.
  - Each channel then decrements by 1 per tick.
- Prescale and enable:
  - prescale=3 -> tick every 4 clocks with value +1 per tick.
  - enable=0 for 10 clocks -> value frozen, no new ticks.
  - Reduce prescale from 100 to 2 while cnt=50 -> step on the next clock.
- Reset mid-run and static mode:
  - Assert rst while mode=2 is descending at value 200 -> next cycle value=0, and the ramp restarts at 0.
  - mode=3 with phase_i=8'h5A -> value_i=8'h5A one clock later; acc frozen; no ticks.
